// File: rtl/int_fsm.sv
// Interrupt-entry sequencer: stalls fetch, injects PUSH CCR / PC low / PC high,
// strobes the vector load, then drains three NOP bubbles.
module int_fsm #(
  parameter logic [15:0] PUSH_CCR_OP     = 16'b0110000010000010,
  parameter logic [15:0] PUSH_PC_LOW_OP  = 16'b0110000010000000,
  parameter logic [15:0] PUSH_PC_HIGH_OP = 16'b0110000010000001,
  parameter logic [15:0] NOP_OP          = 16'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        rti_busy,
  output logic [15:0] out,
  output logic        stall,
  output logic        vec_load,
  output logic        pending
);

  localparam int unsigned INSN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_PUSH_CCR     = 3'd1,
    S_PUSH_PC_LOW  = 3'd2,
    S_PUSH_PC_HIGH = 3'd3,
    S_LOAD_VEC     = 3'd4,
    S_NOP_1        = 3'd5,
    S_NOP_2        = 3'd6,
    S_NOP_3        = 3'd7
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_pending;
  logic [INSN_W-1:0]   r_out;
  logic                r_stall;
  logic                r_vec_load;

  logic                w_go;
  logic                w_enter;
  logic                w_pending;
  logic [INSN_W-1:0]   w_out;
  logic                w_stall;
  logic                w_vec_load;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, pending update, and output decode of the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    w_next     = r_state;
    w_go       = (int_req | r_pending) & ~rti_busy;
    w_enter    = 1'b0;
    w_pending  = r_pending;
    w_out      = NOP_OP;
    w_stall    = 1'b0;
    w_vec_load = 1'b0;

    case (r_state)
      S_IDLE:         w_next = w_go ? S_PUSH_CCR : S_IDLE;
      S_PUSH_CCR:     w_next = S_PUSH_PC_LOW;
      S_PUSH_PC_LOW:  w_next = S_PUSH_PC_HIGH;
      S_PUSH_PC_HIGH: w_next = S_LOAD_VEC;
      S_LOAD_VEC:     w_next = S_NOP_1;
      S_NOP_1:        w_next = S_NOP_2;
      S_NOP_2:        w_next = S_NOP_3;
      S_NOP_3:        w_next = w_go ? S_PUSH_CCR : S_IDLE;
      default:        w_next = S_IDLE;
    endcase

    // Entry consumes the request; a request that cannot enter is remembered.
    w_enter = (w_next == S_PUSH_CCR);
    if (w_enter) begin
      w_pending = 1'b0;
    end else if (int_req) begin
      w_pending = 1'b1;
    end

    case (w_next)
      S_IDLE: begin
        w_out   = NOP_OP;
        w_stall = 1'b0;
      end
      S_PUSH_CCR: begin
        w_out   = PUSH_CCR_OP;
        w_stall = 1'b1;
      end
      S_PUSH_PC_LOW: begin
        w_out   = PUSH_PC_LOW_OP;
        w_stall = 1'b1;
      end
      S_PUSH_PC_HIGH: begin
        w_out   = PUSH_PC_HIGH_OP;
        w_stall = 1'b1;
      end
      S_LOAD_VEC: begin
        w_out      = NOP_OP;
        w_stall    = 1'b1;
        w_vec_load = 1'b1;
      end
      default: begin
        w_out   = NOP_OP;
        w_stall = 1'b1;
      end
    endcase
  end

  // Registered outputs and pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= 1'b0;
      r_out      <= INSN_W'(0);
      r_stall    <= 1'b0;
      r_vec_load <= 1'b0;
    end else begin
      r_pending  <= w_pending;
      r_out      <= w_out;
      r_stall    <= w_stall;
      r_vec_load <= w_vec_load;
    end
  end

  assign out      = r_out;
  assign stall    = r_stall;
  assign vec_load = r_vec_load;
  assign pending  = r_pending;

endmodule

// File: tb/tb_int_fsm.sv
// Scoreboard bench for int_fsm: a sequence-position model queues expected
// outputs per driven cycle; they are popped and compared after each edge.
module tb_int_fsm;

  typedef struct {
    logic [15:0] out;
    logic        stall;
    logic        vec;
    logic        pend;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        int_req;
  logic        rti_busy;
  logic [15:0] out;
  logic        stall;
  logic        vec_load;
  logic        pending;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_err;

  // model: position 0 = idle, 1..7 = stalled cycle number within a sequence
  int          m_pos;
  logic        m_pend;

  int_fsm dut (
    .clk      (clk),
    .reset    (reset),
    .int_req  (int_req),
    .rti_busy (rti_busy),
    .out      (out),
    .stall    (stall),
    .vec_load (vec_load),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need run completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h need %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pos_out(input int pos);
    case (pos)
      1:       return 16'h6082;
      2:       return 16'h6080;
      3:       return 16'h6081;
      default: return 16'h0000;
    endcase
  endfunction

  // drive one cycle, queue its expected result, then compare after the edge
  task automatic cyc(input logic rst, input logic req, input logic busy);
    exp_t e;
    exp_t g;
    logic enter;
    @(negedge clk);
    reset    = rst;
    int_req  = req;
    rti_busy = busy;
    if (rst) begin
      m_pos  = 0;
      m_pend = 1'b0;
    end else begin
      enter = (m_pos == 0 || m_pos == 7) && (req || m_pend) && !busy;
      if (enter)        m_pend = 1'b0;
      else if (req)     m_pend = 1'b1;
      if (enter)                         m_pos = 1;
      else if (m_pos == 0 || m_pos == 7) m_pos = 0;
      else                               m_pos = m_pos + 1;
    end
    e.out   = pos_out(m_pos);
    e.stall = (m_pos != 0);
    e.vec   = (m_pos == 4);
    e.pend  = m_pend;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 16'd1, 16'd0);
    end else begin
      g = sb_q.pop_front();
      check("out",      out,              g.out);
      check("stall",    16'(stall),       16'(g.stall));
      check("vec_load", 16'(vec_load),    16'(g.vec));
      check("pending",  16'(pending),     16'(g.pend));
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    m_pos    = 0;
    m_pend   = 1'b0;
    reset    = 1'b1;
    int_req  = 1'b1;
    rti_busy = 1'b0;

    // reset held two cycles with a request present
    cyc(1, 1, 0);
    cyc(1, 1, 0);

    // single-cycle request from idle: full sequence then idle
    cyc(0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0);
    check("seq_done_idle", 16'(stall), 16'd0);

    // request blocked by rti_busy, entered once busy drops
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("busy_release_entry", out, 16'h6082);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);

    // request during PUSH_PC_LOW: back-to-back re-entry after NOP_3
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0);

    // NOP_3 with request while rti_busy: pending held, entry when busy drops
    cyc(0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);

    // request held for 20 cycles: repeated sequences without a gap
    for (int i = 0; i < 20; i++) cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0);

    // reset during NOP_1 aborts the sequence
    cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    check("at_nop1_vec_clear", 16'(vec_load), 16'd0);
    cyc(1, 0, 0);
    check("reset_mid_out", out, 16'h0000);
    cyc(0, 0, 0);

    // randomized mix of requests, busy and occasional reset
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    check("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
